// File: rtl/boton_acondicionador.sv
// Button conditioning: 2-FF sync, counter debounce, press/release pulses.
// Optional auto-repeat on pulso enabled by defining BOTON_AUTOREPEAT_EN.
module boton_acondicionador #(
  parameter int unsigned       N_BTN           = 4,
  parameter int unsigned       DEBOUNCE_CYCLES = 320000,
  parameter int unsigned       CNT_W           = 24,
  parameter int unsigned       REPEAT_DELAY    = 8000000,
  parameter int unsigned       REPEAT_PERIOD   = 3200000,
  parameter logic [N_BTN-1:0]  REPEAT_MASK     = 4'b0011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] nivel,
  output logic [N_BTN-1:0] pulso,
  output logic [N_BTN-1:0] suelta
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 ||
      64'(DEBOUNCE_CYCLES - 1) >= (64'(1) << CNT_W)) begin : g_bad_deb
    $error("boton_acondicionador: DEBOUNCE_CYCLES does not fit CNT_W");
  end

  if ((|REPEAT_MASK) &&
      (REPEAT_DELAY < 2 || REPEAT_PERIOD == 0 ||
       REPEAT_PERIOD > REPEAT_DELAY)) begin : g_bad_rpt
    $error("boton_acondicionador: bad auto-repeat timing");
  end

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] nivel_q, nivel_d;
  logic [N_BTN-1:0] pulso_q, pulso_d;
  logic [N_BTN-1:0] suelta_q, suelta_d;
  logic [N_BTN-1:0] accept;
  logic [N_BTN-1:0] rpt_fire;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

  always_comb begin
    nivel_d = nivel_q;
    accept  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == nivel_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]   = '0;
        nivel_d[i] = sync2_q[i];
        accept[i]  = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    pulso_d  = (accept & sync2_q) | rpt_fire;
    suelta_d = accept & nivel_q;
  end

`ifdef BOTON_AUTOREPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD =
    RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_q [N_BTN];
  logic [RPT_W-1:0] rpt_d [N_BTN];

  // Reloading below the terminal count spaces later pulses by REPEAT_PERIOD.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rpt_d[i] = '0;
      if (REPEAT_MASK[i] && nivel_q[i] && nivel_d[i]) begin
        if (rpt_q[i] == RPT_LAST) begin
          rpt_fire[i] = 1'b1;
          rpt_d[i]    = RPT_RELOAD;
        end else begin
          rpt_d[i] = rpt_q[i] + RPT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BTN; i++) begin
      if (reset) rpt_q[i] <= '0;
      else       rpt_q[i] <= rpt_d[i];
    end
  end
`else
  assign rpt_fire = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      nivel_q  <= '0;
      pulso_q  <= '0;
      suelta_q <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= ~btn_n;
      sync2_q  <= sync1_q;
      nivel_q  <= nivel_d;
      pulso_q  <= pulso_d;
      suelta_q <= suelta_d;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign nivel  = nivel_q;
  assign pulso  = pulso_q;
  assign suelta = suelta_q;

endmodule
